// File: rtl/conc_trace_recorder.sv
// ----------------------------------------------------------------------------
// conc_trace_recorder
//
// Capture-side companion of the opcode stimulus replayer. While capturing, it
// stores one {op_in, x_obs} entry per clock into an internal trace RAM. Once
// capture is finished, the stored trace streams out over a valid/ready port.
//
// Optional feature macro: CONC_TRACE_TRIG_EN
//   When defined, arm enters a WAIT_TRIG state. Capture begins on the first
//   cycle with op_in[7] (__obs) set, and that cycle is stored as entry 0.
//   When undefined, arm goes straight to CAPTURE.
//
// Parameters
//   DEPTH  trace entries (2..4096)
//   XW     width of the DUT output bus x_obs
//   PCW    width of the cycle counter, count and start_pc
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   op_in     in   sampled opcode {__obs, stbi, x_in[5:0]}
//   x_obs     in   DUT output sampled in the same cycle
//   arm       in   start capture (honoured only in IDLE)
//   stop      in   end capture early (honoured only while capturing/waiting)
//   dump_req  in   start readout (honoured only in DONE)
//   rd_data   out  {op, x_obs} entry being presented
//   rd_valid  out  rd_data valid
//   rd_ready  in   consumer accepts when rd_valid && rd_ready
//   rd_last   out  presented entry is the final stored entry
//   count     out  number of entries stored in the current trace
//   start_pc  out  cycle counter value at the first stored sample
//   busy      out  state is not IDLE
//   full      out  count == DEPTH
// ----------------------------------------------------------------------------
module conc_trace_recorder #(
    parameter int DEPTH = 100,
    parameter int XW    = 6,
    parameter int PCW   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        op_in,
    input  logic [XW-1:0]     x_obs,
    input  logic              arm,
    input  logic              stop,
    input  logic              dump_req,
    output logic [8+XW-1:0]   rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last,
    output logic [PCW-1:0]    count,
    output logic [PCW-1:0]    start_pc,
    output logic              busy,
    output logic              full
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = 8 + XW;

    localparam logic [PW-1:0]  PTR_ONE    = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]  PTR_ZERO   = {PW{1'b0}};
    localparam logic [PW-1:0]  LAST_SLOT  = PW'(DEPTH - 1);
    localparam logic [PW-1:0]  FULL_COUNT = PW'(DEPTH);
    localparam logic [PCW-1:0] PC_ONE     = {{(PCW-1){1'b0}}, 1'b1};

    localparam logic [2:0] ST_IDLE      = 3'd0;
`ifdef CONC_TRACE_TRIG_EN
    localparam logic [2:0] ST_WAIT_TRIG = 3'd1;
`endif
    localparam logic [2:0] ST_CAPTURE   = 3'd2;
    localparam logic [2:0] ST_DONE      = 3'd3;
    localparam logic [2:0] ST_DUMP      = 3'd4;

    logic [DW-1:0]  mem_r [0:DEPTH-1];

    logic [2:0]     state_r;
    logic [2:0]     state_nxt_s;
    logic [PW-1:0]  count_r;
    logic [PW-1:0]  count_nxt_s;
    logic [PW-1:0]  rd_ptr_r;
    logic [PW-1:0]  rd_ptr_nxt_s;
    logic [PCW-1:0] pc_r;
    logic [PCW-1:0] start_pc_r;
    logic [PCW-1:0] start_pc_nxt_s;
    logic [DW-1:0]  rd_data_r;
    logic           rd_valid_r;
    logic           rd_valid_nxt_s;
    logic           rd_last_r;
    logic           rd_last_nxt_s;
    logic           busy_r;
    logic           full_r;
    logic           wr_en_s;
    logic           rd_load_s;
    logic [PW-1:0]  last_idx_s;
    logic [AW-1:0]  wr_addr_s;
    logic [AW-1:0]  rd_addr_s;

    assign last_idx_s = count_r - PTR_ONE;
    assign wr_addr_s  = count_r[AW-1:0];
    assign rd_addr_s  = rd_ptr_r[AW-1:0];

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign rd_last  = rd_last_r;
    assign count    = PCW'(count_r);
    assign start_pc = start_pc_r;
    assign busy     = busy_r;
    assign full     = full_r;

    // Next-state, write-enable and read-fetch decisions for the capture/dump FSM.
    always_comb begin
        state_nxt_s    = state_r;
        count_nxt_s    = count_r;
        rd_ptr_nxt_s   = rd_ptr_r;
        start_pc_nxt_s = start_pc_r;
        rd_valid_nxt_s = rd_valid_r;
        rd_last_nxt_s  = rd_last_r;
        wr_en_s        = 1'b0;
        rd_load_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arm) begin
                    count_nxt_s  = PTR_ZERO;
                    rd_ptr_nxt_s = PTR_ZERO;
`ifdef CONC_TRACE_TRIG_EN
                    state_nxt_s  = ST_WAIT_TRIG;
`else
                    state_nxt_s  = ST_CAPTURE;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
`ifdef CONC_TRACE_TRIG_EN
            ST_WAIT_TRIG: begin
                // stop wins over a coincident trigger: the trace stays empty.
                if (stop) begin
                    state_nxt_s = ST_DONE;
                end else if (op_in[7]) begin
                    wr_en_s        = 1'b1;
                    count_nxt_s    = PTR_ONE;
                    start_pc_nxt_s = pc_r;
                    state_nxt_s    = ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_WAIT_TRIG;
                end
            end
`endif
            ST_CAPTURE: begin
                // Every CAPTURE cycle stores a sample, including the one that carries stop.
                wr_en_s     = 1'b1;
                count_nxt_s = count_r + PTR_ONE;
                if (count_r == PTR_ZERO) begin
                    start_pc_nxt_s = pc_r;
                end else begin
                    start_pc_nxt_s = start_pc_r;
                end
                if (stop || (count_r == LAST_SLOT)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CAPTURE;
                end
            end
            ST_DONE: begin
                if (dump_req) begin
                    rd_ptr_nxt_s = PTR_ZERO;
                    if (count_r == PTR_ZERO) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DUMP;
                    end
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_DUMP: begin
                if (rd_valid_r && rd_ready && rd_last_r) begin
                    rd_valid_nxt_s = 1'b0;
                    rd_last_nxt_s  = 1'b0;
                    state_nxt_s    = ST_IDLE;
                end else if ((!rd_valid_r || rd_ready) && (rd_ptr_r < count_r)) begin
                    // Fetch the next entry on the accepting edge so there is no bubble.
                    rd_load_s      = 1'b1;
                    rd_valid_nxt_s = 1'b1;
                    rd_last_nxt_s  = (rd_ptr_r == last_idx_s);
                    rd_ptr_nxt_s   = rd_ptr_r + PTR_ONE;
                end else if (rd_valid_r && rd_ready) begin
                    rd_valid_nxt_s = 1'b0;
                    rd_last_nxt_s  = 1'b0;
                end else begin
                    rd_valid_nxt_s = rd_valid_r;
                    rd_last_nxt_s  = rd_last_r;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                rd_valid_nxt_s = 1'b0;
                rd_last_nxt_s  = 1'b0;
            end
        endcase
    end

    // FSM state, counters, status flags and the registered read port.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            count_r    <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            pc_r       <= {PCW{1'b0}};
            start_pc_r <= {PCW{1'b0}};
            rd_data_r  <= {DW{1'b0}};
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
            busy_r     <= 1'b0;
            full_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            count_r    <= count_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            pc_r       <= pc_r + PC_ONE;
            start_pc_r <= start_pc_nxt_s;
            rd_valid_r <= rd_valid_nxt_s;
            rd_last_r  <= rd_last_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
            full_r     <= (count_nxt_s == FULL_COUNT);
            if (rd_load_s) begin
                rd_data_r <= mem_r[rd_addr_s];
            end
        end
    end

    // Trace RAM write port; contents need no reset.
    always_ff @(posedge clock) begin
        if (wr_en_s && !reset) begin
            mem_r[wr_addr_s] <= {op_in, x_obs};
        end
    end

endmodule

// File: tb/tb_conc_trace_recorder.sv
module tb_conc_trace_recorder;

    localparam int XW  = 6;
    localparam int PCW = 32;
    localparam int DW  = 8 + XW;

`ifdef CONC_TRACE_TRIG_EN
    localparam logic [7:0] FIRST_OR = 8'h80;
`else
    localparam logic [7:0] FIRST_OR = 8'h00;
`endif

    logic           clock = 1'b0;
    logic           reset;
    logic [7:0]     op_in;
    logic [XW-1:0]  x_obs;

    logic           arm_a, stop_a, dump_req_a, rd_ready_a;
    logic [DW-1:0]  rd_data_a;
    logic           rd_valid_a, rd_last_a, busy_a, full_a;
    logic [PCW-1:0] count_a, start_pc_a;

    logic           arm_b, stop_b, dump_req_b, rd_ready_b;
    logic [DW-1:0]  rd_data_b;
    logic           rd_valid_b, rd_last_b, busy_b, full_b;
    logic [PCW-1:0] count_b, start_pc_b;

    int checks = 0;
    int passes = 0;
    logic [PCW-1:0] tb_pc;
    logic [DW-1:0]  q_a[$];
    logic [DW-1:0]  q_b[$];

    typedef struct {
        logic [7:0] op;
        logic [5:0] x;
        logic       stp;
        int         exp_count;
        logic       exp_full;
    } vec_t;

    vec_t t1[5];
    vec_t t2[10];

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset) tb_pc <= '0;
        else       tb_pc <= tb_pc + 32'd1;
    end

    conc_trace_recorder #(.DEPTH(100), .XW(XW), .PCW(PCW)) u_dut (
        .clock(clock), .reset(reset), .op_in(op_in), .x_obs(x_obs),
        .arm(arm_a), .stop(stop_a), .dump_req(dump_req_a),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_ready(rd_ready_a),
        .rd_last(rd_last_a), .count(count_a), .start_pc(start_pc_a),
        .busy(busy_a), .full(full_a)
    );

    conc_trace_recorder #(.DEPTH(4), .XW(XW), .PCW(PCW)) u_small (
        .clock(clock), .reset(reset), .op_in(op_in), .x_obs(x_obs),
        .arm(arm_b), .stop(stop_b), .dump_req(dump_req_b),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_ready(rd_ready_b),
        .rd_last(rd_last_b), .count(count_b), .start_pc(start_pc_b),
        .busy(busy_b), .full(full_b)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    // mode 0: rd_ready always high; mode 1: rd_ready pattern 1,0,0,1,0,0...
    // stop_after > 0 leaves the dump in progress after that many acceptances.
    task automatic dump_a(input int mode, input int stop_after);
        logic [DW-1:0] held_data;
        logic [DW-1:0] exp;
        logic          held_last;
        logic          stalled;
        logic          rdy;
        int            acc;
        bit            done;
        dump_req_a = 1'b1;
        step();
        dump_req_a = 1'b0;
        chk("dump_first_cycle_valid", rd_valid_a, 1'b0);
        chk("dump_busy", busy_a, 1'b1);
        step();
        stalled = 1'b0;
        held_data = '0;
        held_last = 1'b0;
        acc = 0;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            rdy = (mode == 0) ? 1'b1 : ((k % 3) == 0);
            rd_ready_a = rdy;
            chk("dump_valid", rd_valid_a, 1'b1);
            if (stalled) begin
                chk("stall_data_stable", rd_data_a, held_data);
                chk("stall_last_stable", rd_last_a, held_last);
            end
            if (rdy) begin
                if (q_a.size() == 0) begin
                    chk("dump_extra_entry", rd_valid_a, 1'b0);
                    done = 1'b1;
                end else begin
                    exp = q_a.pop_front();
                    chk("dump_data", rd_data_a, exp);
                    chk("dump_last", rd_last_a, (q_a.size() == 0));
                    acc++;
                    if (q_a.size() == 0) begin
                        step();
                        rd_ready_a = 1'b0;
                        chk("dump_end_valid", rd_valid_a, 1'b0);
                        chk("dump_end_busy", busy_a, 1'b0);
                        done = 1'b1;
                    end else if (acc == stop_after) begin
                        step();
                        rd_ready_a = 1'b0;
                        done = 1'b1;
                    end
                end
            end
            if (!done) begin
                held_data = rd_data_a;
                held_last = rd_last_a;
                stalled = !rdy;
                step();
            end
        end
        if (!done) chk("dump_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [PCW-1:0] exp_start;
        logic [7:0]     op;
        logic [5:0]     xv;

        for (int i = 0; i < 5; i++)
            t1[i] = '{op: 8'(i), x: 6'(i), stp: (i == 4), exp_count: i + 1, exp_full: 1'b0};
        for (int i = 0; i < 10; i++)
            t2[i] = '{op: 8'(8'h40 + i), x: 6'(20 + i), stp: (i == 6),
                      exp_count: (i < 4) ? i + 1 : 4, exp_full: (i >= 3)};

        reset = 1'b1; op_in = '0; x_obs = '0;
        arm_a = 1'b0; stop_a = 1'b0; dump_req_a = 1'b0; rd_ready_a = 1'b0;
        arm_b = 1'b0; stop_b = 1'b0; dump_req_b = 1'b0; rd_ready_b = 1'b0;
        step();
        step();
        chk("rst_count", count_a, 32'd0);
        chk("rst_start_pc", start_pc_a, 32'd0);
        chk("rst_rd_data", rd_data_a, 14'd0);
        chk("rst_rd_valid", rd_valid_a, 1'b0);
        chk("rst_rd_last", rd_last_a, 1'b0);
        chk("rst_full", full_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        reset = 1'b0;

        // Basic capture of five samples, stop arriving with the fifth.
        arm_a = 1'b1;
        step();
        arm_a = 1'b0;
        chk("t1_busy_armed", busy_a, 1'b1);
        chk("t1_count_armed", count_a, 32'd0);
        exp_start = '0;
        for (int i = 0; i < 5; i++) begin
            op = t1[i].op | ((i == 0) ? FIRST_OR : 8'h00);
            op_in = op;
            x_obs = t1[i].x;
            stop_a = t1[i].stp;
            if (i == 0) exp_start = tb_pc;
            q_a.push_back({op, t1[i].x});
            step();
            chk("t1_count", count_a, 32'(t1[i].exp_count));
            chk("t1_full", full_a, t1[i].exp_full);
        end
        stop_a = 1'b0;
        chk("t1_start_pc", start_pc_a, exp_start);
        op_in = 8'h11;
        step();
        chk("t1_done_holds_count", count_a, 32'd5);

        // arm in DONE is ignored; trace and count survive.
        arm_a = 1'b1;
        op_in = 8'h3f;
        step();
        arm_a = 1'b0;
        chk("t5_arm_in_done_count", count_a, 32'd5);
        chk("t5_arm_in_done_busy", busy_a, 1'b1);
        dump_a(0, -1);
        chk("t1_count_after_dump", count_a, 32'd5);

        // stop in IDLE is ignored.
        stop_a = 1'b1;
        step();
        stop_a = 1'b0;
        chk("t5_stop_in_idle_busy", busy_a, 1'b0);
        chk("t5_stop_in_idle_count", count_a, 32'd5);

        // Depth-limited capture on the 4-entry instance.
        arm_b = 1'b1;
        step();
        arm_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            op = t2[i].op | ((i == 0) ? FIRST_OR : 8'h00);
            op_in = op;
            x_obs = t2[i].x;
            stop_b = t2[i].stp;
            if (i < 4) q_b.push_back({op, t2[i].x});
            step();
            chk("t2_count", count_b, 32'(t2[i].exp_count));
            chk("t2_full", full_b, t2[i].exp_full);
            chk("t2_busy", busy_b, 1'b1);
        end
        stop_b = 1'b0;
        dump_req_b = 1'b1;
        step();
        dump_req_b = 1'b0;
        chk("t2_first_cycle_valid", rd_valid_b, 1'b0);
        step();
        rd_ready_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t2_valid", rd_valid_b, 1'b1);
            if (q_b.size() != 0) chk("t2_data", rd_data_b, q_b.pop_front());
            else chk("t2_queue_underrun", 1'b1, 1'b0);
            chk("t2_last", rd_last_b, (k == 3));
            step();
        end
        rd_ready_b = 1'b0;
        chk("t2_end_valid", rd_valid_b, 1'b0);
        chk("t2_end_busy", busy_b, 1'b0);

        // Random trace dumped with a stalling consumer.
        arm_a = 1'b1;
        step();
        arm_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            op = 8'($urandom_range(0, 255)) | ((i == 0) ? FIRST_OR : 8'h00);
            xv = 6'($urandom_range(0, 63));
            op_in = op;
            x_obs = xv;
            stop_a = (i == 5);
            q_a.push_back({op, xv});
            step();
        end
        stop_a = 1'b0;
        chk("t3_count", count_a, 32'd6);
        dump_a(1, -1);

        // Reset in the middle of a dump.
        arm_a = 1'b1;
        step();
        arm_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            op = 8'(8'h20 + i) | ((i == 0) ? FIRST_OR : 8'h00);
            op_in = op;
            x_obs = 6'(i + 7);
            stop_a = (i == 3);
            q_a.push_back({op, 6'(i + 7)});
            step();
        end
        stop_a = 1'b0;
        dump_a(0, 2);
        chk("t4_still_dumping", rd_valid_a, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        q_a.delete();
        chk("t4_rd_valid", rd_valid_a, 1'b0);
        chk("t4_count", count_a, 32'd0);
        chk("t4_busy", busy_a, 1'b0);

`ifdef CONC_TRACE_TRIG_EN
        // Trigger-qualified capture.
        arm_a = 1'b1;
        step();
        arm_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op_in = 8'(i);
            x_obs = 6'(i);
            step();
            chk("t6_wait_count", count_a, 32'd0);
        end
        op_in = 8'h85;
        x_obs = 6'd5;
        exp_start = tb_pc;
        q_a.push_back({8'h85, 6'd5});
        step();
        op_in = 8'h01;
        x_obs = 6'd1;
        stop_a = 1'b1;
        q_a.push_back({8'h01, 6'd1});
        step();
        stop_a = 1'b0;
        chk("t6_count", count_a, 32'd2);
        chk("t6_start_pc", start_pc_a, exp_start);
        dump_a(0, -1);

        // stop while waiting for the trigger leaves an empty trace.
        op_in = 8'h00;
        arm_a = 1'b1;
        step();
        arm_a = 1'b0;
        stop_a = 1'b1;
        step();
        stop_a = 1'b0;
        chk("t6_empty_count", count_a, 32'd0);
        chk("t6_empty_busy", busy_a, 1'b1);
        dump_req_a = 1'b1;
        step();
        dump_req_a = 1'b0;
        chk("t6_empty_idle", busy_a, 1'b0);
        chk("t6_empty_valid", rd_valid_a, 1'b0);
        step();
        chk("t6_empty_valid2", rd_valid_a, 1'b0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
